dmem_stall_ctrl: RTL and testbench

DMEM_STALL_CTRL -- requirements
Module: dmem_stall_ctrl

---
 rtl/dmem_stall_ctrl_if.sv | 31 +++
 rtl/dmem_stall_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_dmem_stall_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_stall_ctrl_if.sv
// rtl/dmem_stall_ctrl_if.sv - data-memory bus between the stall controller and the memory
//
// Purpose: groups the word-aligned request/response bus of the data memory.
// Signals:
//   mem_req    request valid, held high for the whole access
//   mem_we     1 = store, 0 = load
//   mem_addr   word-aligned byte address (bits [1:0] always 00)
//   mem_wdata  store data, replicated across the byte lanes
//   mem_be     byte-lane enables
//   mem_ready  memory completes the access this cycle
//   mem_rdata  load data, full word
// Modports: master = controller side, slave = memory side.
interface dmem_stall_ctrl_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/dmem_stall_ctrl.sv
// rtl/dmem_stall_ctrl.sv - MEM-stage data memory access controller with pipeline stall
//
// Purpose: turns the MEM-stage load/store into a held request on the memory
// bus, stalls the pipeline until the memory answers (or a timeout expires),
// produces the size/sign-extended load result and flags bad accesses.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   EX_MEMmemRead     MEM-stage instruction is a load (wins if both set)
//   EX_MEMmemWrite    MEM-stage instruction is a store
//   EX_MEMaddr        byte address
//   EX_MEMwdata       right-aligned store data
//   EX_MEMfunct3      access size / signedness
//   memStall          holds PC and pipeline registers
//   readData          extended load result, valid in DONE
//   memErr            one-cycle pulse: misaligned, illegal size or timeout
//   mem               memory bus (master side)
module dmem_stall_ctrl #(
   parameter int TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               EX_MEMmemRead,
   input  logic               EX_MEMmemWrite,
   input  logic [31:0]        EX_MEMaddr,
   input  logic [31:0]        EX_MEMwdata,
   input  logic [2:0]         EX_MEMfunct3,
   output logic               memStall,
   output logic [31:0]        readData,
   output logic               memErr,
   dmem_stall_ctrl_if.master  mem
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;
   logic          req_q, req_d;
   logic          we_q, we_d;
   logic [3:0]    be_q, be_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [2:0]    f3_q, f3_d;
   logic [1:0]    lane_q, lane_d;

   logic          access;
   logic          bad;
   logic [3:0]    be_new;
   logic [31:0]   wdata_new;
   logic [31:0]   shifted;
   logic [31:0]   load_ext;
   logic [CW-1:0] cnt_inc;
   logic          stall;

   // Access decode; size comes from funct3[1:0], bit 2 only selects zero-extension.
   always_comb begin
      access = EX_MEMmemRead | EX_MEMmemWrite;
      bad    = 1'b0;
      be_new = 4'b1111;
      wdata_new = EX_MEMwdata;
      case (EX_MEMfunct3[1:0])
         2'b00: begin
            be_new    = 4'b0001 << EX_MEMaddr[1:0];
            wdata_new = {4{EX_MEMwdata[7:0]}};
         end
         2'b01: begin
            be_new    = 4'b0011 << EX_MEMaddr[1:0];
            wdata_new = {2{EX_MEMwdata[15:0]}};
            bad       = EX_MEMaddr[0];
         end
         default: begin
            bad = (EX_MEMaddr[1:0] != 2'b00);
         end
      endcase
      if (EX_MEMfunct3 == 3'b011 || EX_MEMfunct3 == 3'b110 || EX_MEMfunct3 == 3'b111) begin
         bad = 1'b1;
      end
   end

   // Lane select and extension of the returned word, using the captured access.
   always_comb begin
      shifted = mem.mem_rdata >> {lane_q, 3'b000};
      case (f3_q)
         3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  load_ext = {24'd0, shifted[7:0]};
         3'b101:  load_ext = {16'd0, shifted[15:0]};
         default: load_ext = mem.mem_rdata;
      endcase
   end

   assign cnt_inc = cnt_q + CW'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = 1'b0;
      req_d   = req_q;
      we_d    = we_q;
      be_d    = be_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      f3_d    = f3_q;
      lane_d  = lane_q;
      stall   = 1'b0;
      case (state_q)
         IDLE: begin
            if (access) begin
               if (bad) begin
                  err_d = 1'b1;
               end else begin
                  stall   = 1'b1;
                  state_d = WAIT;
                  cnt_d   = '0;
                  req_d   = 1'b1;
                  we_d    = ~EX_MEMmemRead;
                  be_d    = be_new;
                  addr_d  = {EX_MEMaddr[31:2], 2'b00};
                  wdata_d = wdata_new;
                  f3_d    = EX_MEMfunct3;
                  lane_d  = EX_MEMaddr[1:0];
               end
            end
         end
         WAIT: begin
            stall = 1'b1;
            // Ready is checked first so a response on the last allowed cycle still completes.
            if (mem.mem_ready) begin
               state_d = DONE;
               req_d   = 1'b0;
               if (!we_q) begin
                  rdata_d = load_ext;
               end
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == CW'(TIMEOUT)) begin
                  state_d = DONE;
                  req_d   = 1'b0;
                  rdata_d = '0;
                  err_d   = 1'b1;
               end
            end
         end
         DONE: begin
            // The instruction is still in MEM this cycle; its request flags are ignored.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         be_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         f3_q    <= '0;
         lane_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         req_q   <= req_d;
         we_q    <= we_d;
         be_q    <= be_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         f3_q    <= f3_d;
         lane_q  <= lane_d;
      end
   end

   // Gating with rst_n keeps the stall low during reset even with an access pending.
   assign memStall      = stall & rst_n;
   assign readData      = rdata_q;
   assign memErr        = err_q;
   assign mem.mem_req   = req_q;
   assign mem.mem_we    = we_q;
   assign mem.mem_be    = be_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// tb/tb_dmem_stall_ctrl.sv - self-checking bench for dmem_stall_ctrl
module tb_dmem_stall_ctrl;
   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [2:0]  f3 = '0;
   logic        memStall;
   logic [31:0] readData;
   logic        memErr;

   dmem_stall_ctrl_if mem ();

   dmem_stall_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .EX_MEMmemRead  (rd),
      .EX_MEMmemWrite (wr),
      .EX_MEMaddr     (addr),
      .EX_MEMwdata    (wdata),
      .EX_MEMfunct3   (f3),
      .memStall       (memStall),
      .readData       (readData),
      .memErr         (memErr),
      .mem            (mem.master)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_rd = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int sz(input logic [2:0] f);
      return 1 << f[1:0];
   endfunction

   function automatic bit m_bad(input logic [2:0] f, input logic [31:0] a);
      if (f == 3 || f == 6 || f == 7) return 1'b1;
      return (a % sz(f)) != 0;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f, input logic [31:0] a);
      int m;
      m = (1 << sz(f)) - 1;
      return 4'((m << (a % 4)) & 15);
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] w);
      logic [63:0] r;
      logic [63:0] mask;
      int s;
      s = sz(f);
      mask = (64'd1 << (8 * s)) - 64'd1;
      r = '0;
      for (int i = 0; i < 4 / s; i++) r = r | ((64'(w) & mask) << (8 * s * i));
      return r[31:0];
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] w);
      logic [63:0] v;
      logic [63:0] mask;
      int s;
      s = sz(f);
      mask = (64'd1 << (8 * s)) - 64'd1;
      v = (64'(w) >> (8 * (a % 4))) & mask;
      if (!f[2] && s < 4 && v[8 * s - 1]) v = v - (64'd1 << (8 * s));
      return v[31:0];
   endfunction

   // One MEM-stage instruction. rdy_at = WAIT cycle on which ready is given, 0 = never.
   task automatic access(input logic r, input logic w, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] wd, input int rdy_at, input logic [31:0] rword);
      bit          bad;
      bit          is_load;
      bit          tmo;
      int          n;
      int          stalls;
      int          exp_waits;
      logic [31:0] word_addr;
      bad = m_bad(f, a);
      is_load = r;
      tmo = (rdy_at == 0 || rdy_at > TIMEOUT);
      exp_waits = tmo ? TIMEOUT : rdy_at;
      word_addr = {a[31:2], 2'b00};
      @(posedge clk);
      #1;
      rd = r; wr = w; f3 = f; addr = a; wdata = wd;
      mem.mem_ready = 1'($urandom_range(0, 1));
      mem.mem_rdata = $urandom;
      #1;
      chk("err_before", memErr, 0);
      chk("req_detect", mem.mem_req, 0);
      chk("stall_detect", memStall, bad ? 0 : 1);
      if (bad) begin
         @(posedge clk);
         #1;
         rd = 0; wr = 0;
         #1;
         chk("bad_err", memErr, 1);
         chk("bad_req", mem.mem_req, 0);
         chk("bad_stall", memStall, 0);
         chk("bad_rdata", readData, exp_rd);
         return;
      end
      stalls = 1;
      n = 0;
      while (n < TIMEOUT) begin
         @(posedge clk);
         #1;
         n++;
         mem.mem_ready = (n == rdy_at);
         mem.mem_rdata = (n == rdy_at) ? rword : $urandom;
         #1;
         chk("wait_req", mem.mem_req, 1);
         chk("wait_addr", mem.mem_addr, word_addr);
         chk("wait_we", mem.mem_we, is_load ? 0 : 1);
         chk("wait_be", mem.mem_be, m_be(f, a));
         if (!is_load) chk("wait_wdata", mem.mem_wdata, m_wdata(f, wd));
         if (memStall) stalls++;
         if (n == rdy_at) break;
      end
      @(posedge clk);
      #1;
      mem.mem_ready = 1'($urandom_range(0, 1));
      mem.mem_rdata = $urandom;
      if (tmo) exp_rd = '0;
      else if (is_load) exp_rd = m_load(f, a, rword);
      #1;
      if (memStall) stalls++;
      chk("done_stall", memStall, 0);
      chk("done_req", mem.mem_req, 0);
      chk("done_rdata", readData, exp_rd);
      chk("done_err", memErr, tmo ? 1 : 0);
      chk("stall_cycles", stalls, exp_waits + 1);
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
      rd = 0; wr = 0;
      mem.mem_ready = 1'($urandom_range(0, 1));
      mem.mem_rdata = $urandom;
      #1;
      chk("idle_stall", memStall, 0);
      chk("idle_req", mem.mem_req, 0);
   endtask

   initial begin
      mem.mem_ready = 1'b1;
      mem.mem_rdata = 32'h1234_5678;
      rd = 1; f3 = 3'b010; addr = 32'h100;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_stall", memStall, 0);
      chk("rst_req", mem.mem_req, 0);
      chk("rst_rdata", readData, 0);
      chk("rst_err", memErr, 0);
      chk("rst_be", mem.mem_be, 0);
      chk("rst_addr", mem.mem_addr, 0);
      chk("rst_wdata", mem.mem_wdata, 0);
      chk("rst_we", mem.mem_we, 0);
      rd = 0;
      rst_n = 1;

      access(1, 0, 3'b010, 32'h100, 0, 1, 32'hDEADBEEF);
      access(1, 0, 3'b000, 32'h103, 0, 1, 32'h80FFFFFF);
      access(1, 0, 3'b100, 32'h103, 0, 2, 32'h80FFFFFF);
      access(0, 1, 3'b001, 32'h102, 32'h0000ABCD, 3, 32'h0);
      access(1, 0, 3'b010, 32'h101, 0, 1, 32'h0);
      access(1, 0, 3'b011, 32'h100, 0, 1, 32'h0);
      access(1, 1, 3'b101, 32'h102, 32'hFFFF_FFFF, 1, 32'h8001_7FFF);
      access(1, 0, 3'b010, 32'h200, 0, 0, 32'h0);
      access(1, 0, 3'b010, 32'h204, 0, TIMEOUT, 32'hCAFEF00D);
      idle_cycle();

      // reset in the second WAIT cycle
      @(posedge clk);
      #1;
      rd = 1; wr = 0; f3 = 3'b010; addr = 32'h300; mem.mem_ready = 0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("mid_req_before", mem.mem_req, 1);
      rst_n = 0;
      #1;
      chk("mid_req", mem.mem_req, 0);
      chk("mid_stall", memStall, 0);
      chk("mid_rdata", readData, 0);
      exp_rd = '0;
      @(posedge clk);
      #1;
      rd = 0;
      rst_n = 1;
      access(1, 0, 3'b010, 32'h304, 0, 1, 32'h0BADC0DE);

      for (int i = 0; i < 150; i++) begin
         logic       r;
         logic       w;
         int         ra;
         int         sel;
         r = 1'($urandom_range(0, 1));
         w = r ? 1'($urandom_range(0, 1)) : 1'b1;
         sel = $urandom_range(0, 9);
         ra = (sel == 0) ? 0 : (sel == 1) ? TIMEOUT : $urandom_range(1, 5);
         access(r, w, 3'($urandom_range(0, 7)), $urandom, $urandom, ra, $urandom);
         if ($urandom_range(0, 3) == 0) idle_cycle();
      end
      idle_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
